// File: rtl/pipeline_memory_stage.sv
// Memory stage of the 16-bit pipeline: services load/store on a req/ack data port,
// passes other instructions through, and presents one registered result per retire.
module pipeline_memory_stage #(
    parameter int          TIMEOUT   = 16,
    parameter logic [15:0] NOP_INSTR = 16'hF000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        execute_valid,
    output logic        execute_ready,
    input  logic [15:0] execute_instr,
    input  logic [15:0] execute_result,
    input  logic [15:0] execute_store_data,
    input  logic        execute_is_dependent,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        memory_done,
    output logic        memory_is_dependent,
    output logic [15:0] memory_result,
    output logic [15:0] memory_instr,
    output logic        mem_fault
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t        state_q, state_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   instr_q, instr_d;
    logic          dep_q, dep_d;
    logic          done_q, done_d;
    logic          mdep_q, mdep_d;
    logic [15:0]   mres_q, mres_d;
    logic [15:0]   minstr_q, minstr_d;
    logic          fault_q, fault_d;
    logic          is_load, is_store;

    assign is_load       = (execute_instr[15:12] == 4'b1000);
    assign is_store      = (execute_instr[15:12] == 4'b1001);
    assign execute_ready = (state_q == IDLE);

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        instr_d  = instr_q;
        dep_d    = dep_q;
        fault_d  = fault_q;
        // Result outputs default to a bubble so writeback never re-writes a held instruction.
        done_d   = 1'b0;
        mdep_d   = 1'b0;
        mres_d   = 16'h0000;
        minstr_d = NOP_INSTR;
        case (state_q)
            IDLE: begin
                if (execute_valid) begin
                    if (is_load || is_store) begin
                        state_d = ACCESS;
                        req_d   = 1'b1;
                        we_d    = is_store;
                        addr_d  = execute_result;
                        wdata_d = execute_store_data;
                        cnt_d   = '0;
                        instr_d = execute_instr;
                        dep_d   = execute_is_dependent;
                    end else begin
                        done_d   = 1'b1;
                        mres_d   = execute_result;
                        minstr_d = execute_instr;
                        mdep_d   = execute_is_dependent;
                    end
                end
            end
            ACCESS: begin
                if (dmem_ack || (cnt_q == CW'(TIMEOUT - 1))) begin
                    state_d  = IDLE;
                    req_d    = 1'b0;
                    done_d   = 1'b1;
                    minstr_d = instr_q;
                    mdep_d   = dep_q;
                    // Ack takes priority over a timeout landing in the same cycle.
                    if (dmem_ack) begin
                        mres_d = we_q ? addr_q : dmem_rdata;
                    end else begin
                        fault_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 16'h0000;
            wdata_q  <= 16'h0000;
            cnt_q    <= '0;
            instr_q  <= NOP_INSTR;
            dep_q    <= 1'b0;
            done_q   <= 1'b0;
            mdep_q   <= 1'b0;
            mres_q   <= 16'h0000;
            minstr_q <= NOP_INSTR;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            instr_q  <= instr_d;
            dep_q    <= dep_d;
            done_q   <= done_d;
            mdep_q   <= mdep_d;
            mres_q   <= mres_d;
            minstr_q <= minstr_d;
            fault_q  <= fault_d;
        end
    end

    assign dmem_req            = req_q;
    assign dmem_we             = we_q;
    assign dmem_addr           = addr_q;
    assign dmem_wdata          = wdata_q;
    assign memory_done         = done_q;
    assign memory_is_dependent = mdep_q;
    assign memory_result       = mres_q;
    assign memory_instr        = minstr_q;
    assign mem_fault           = fault_q;

endmodule
